// File: rtl/tone_select_if.sv
// Button inputs and tone-select outputs of tone_select_ctrl.
// Buttons are raw levels with no handshake; step is a one-cycle pulse in the cycle Q changes.
interface tone_select_if #(
    parameter int N_POS = 20
);
    logic             btn1;
    logic             btn2;
    logic [N_POS-1:0] Q;
    logic             step;
    logic             at_top;
    logic             at_bottom;

    modport master (
        output btn1, btn2,
        input  Q, step, at_top, at_bottom
    );

    modport slave (
        input  btn1, btn2,
        output Q, step, at_top, at_bottom
    );
endinterface

// File: rtl/tone_select_ctrl.sv
// Synchronises and debounces the up/down buttons and steps a saturating one-hot
// tone select, with auto-repeat while a single button is held.
module tone_select_ctrl #(
    parameter int N_POS         = 20,
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_DELAY  = 2500000,
    parameter int REPEAT_PERIOD = 500000
) (
    input  logic       clk,
    input  logic       _rst,
    tone_select_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]    T_DELAY  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0]    T_PERIOD = TW'(REPEAT_PERIOD);
    localparam logic [TW-1:0]    T_ONE    = TW'(1);
    localparam logic [N_POS-1:0] Q_TOP    = {1'b1, {(N_POS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_t;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]    raw, meta, sync, deb, deb_q, rise;
    logic [DW-1:0] cnt [2];

    state_t           state;
    logic [TW-1:0]    timer;
    logic [N_POS-1:0] q_r;
    logic             step_r;
    logic             up_req, dn_req;

    assign raw  = {bus.btn2, bus.btn1};
    assign rise = deb & ~deb_q;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            meta   <= '0;
            sync   <= '0;
            deb    <= '0;
            deb_q  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] != deb[i]) begin
                    if (cnt[i] == DEB_LAST) begin
                        deb[i] <= sync[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Step requests; saturation at either end is applied where Q is updated.
    always_comb begin
        up_req = 1'b0;
        dn_req = 1'b0;
        case (state)
            IDLE: begin
                up_req = rise[0] && !rise[1] && !deb[1];
                dn_req = rise[1] && !rise[0] && !deb[0];
            end
            HOLD_UP: up_req = deb[0] && !deb[1] && (timer == T_ONE);
            HOLD_DN: dn_req = deb[1] && !deb[0] && (timer == T_ONE);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state  <= IDLE;
            timer  <= '0;
            q_r    <= Q_TOP;
            step_r <= 1'b0;
        end else begin
            step_r <= 1'b0;
            if (up_req && !q_r[N_POS-1]) begin
                q_r    <= q_r << 1;
                step_r <= 1'b1;
            end else if (dn_req && !q_r[0]) begin
                q_r    <= q_r >> 1;
                step_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rise[0] && rise[1]) begin
                        state <= LOCK;
                    end else if (rise[0] && !deb[1]) begin
                        state <= HOLD_UP;
                        timer <= T_DELAY;
                    end else if (rise[1] && !deb[0]) begin
                        state <= HOLD_DN;
                        timer <= T_DELAY;
                    end
                end
                HOLD_UP: begin
                    if (!deb[0])     state <= IDLE;
                    else if (deb[1]) state <= LOCK;
                    else             timer <= (timer == T_ONE) ? T_PERIOD : timer - T_ONE;
                end
                HOLD_DN: begin
                    if (!deb[1])     state <= IDLE;
                    else if (deb[0]) state <= LOCK;
                    else             timer <= (timer == T_ONE) ? T_PERIOD : timer - T_ONE;
                end
                LOCK: begin
                    // A button still held here needs a fresh press after exit.
                    if (!deb[0] && !deb[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Q         = q_r;
    assign bus.step      = step_r;
    assign bus.at_top    = q_r[N_POS-1];
    assign bus.at_bottom = q_r[0];
    assign dbg_state     = state;

endmodule
